// File: rtl/instr_encoder_pkg.sv
// Shared RISC-V opcode constants, instruction formats, immediate range limits
// and encoder FSM states for instr_encoder and its field packer.
package instr_encoder_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_NONE
  } fmt_t;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_S_MIN = -2048;
  localparam int IMM_S_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FULL
  } state_t;

  function automatic fmt_t opc_fmt(input logic [6:0] op);
    case (op)
      OPC_LOAD, OPC_OPIMM: opc_fmt = FMT_I;
      OPC_STORE:           opc_fmt = FMT_S;
      OPC_BRANCH:          opc_fmt = FMT_B;
      default:             opc_fmt = FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: opcode/registers/funct3/immediate -> 32-bit word,
// plus format-supported and immediate-in-range flags.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        fmt_ok,
  output logic        imm_ok
);

  int simm;

  always_comb begin
    simm   = imm;
    word   = '0;
    fmt_ok = 1'b1;
    imm_ok = 1'b1;
    case (opc_fmt(opcode))
      FMT_I: begin
        word   = {imm[11:0], rs1, funct3, rd, opcode};
        imm_ok = (simm >= IMM_I_MIN) && (simm <= IMM_I_MAX);
      end
      FMT_S: begin
        word   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        imm_ok = (simm >= IMM_S_MIN) && (simm <= IMM_S_MAX);
      end
      FMT_B: begin
        // imm[0] is implicit zero in branch offsets; it only matters for the range check
        word   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        imm_ok = !imm[0] && (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX);
      end
      default: fmt_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RISC-V fields into instruction words and streams them to
// instruction memory at consecutive addresses. Define IMM_CHECK_EN to range-check immediates.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   wr_count,
  output logic              full,
  output logic              bad_op,
  output logic              imm_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  state_t      state;
  logic [31:0] word;
  logic        fmt_ok, imm_ok, good;
  logic        accept, wr_done, last_done;

  instr_pack u_pack (
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .imm    (in_imm),
    .word   (word),
    .fmt_ok (fmt_ok),
    .imm_ok (imm_ok)
  );

  assign in_ready  = !rst && !clr && !full && (!wr_en || wr_ready);
  assign accept    = in_valid && in_ready;
  assign wr_done   = wr_en && wr_ready;
  assign last_done = wr_done && (wr_addr == LAST_ADDR);

`ifdef IMM_CHECK_EN
  assign good = fmt_ok && imm_ok;

  always_ff @(posedge clk) begin
    if (rst || clr) imm_err <= 1'b0;
    else            imm_err <= accept && fmt_ok && !imm_ok;
  end
`else
  logic unused_imm_ok;
  assign good          = fmt_ok;
  assign imm_err       = 1'b0;
  assign unused_imm_ok = imm_ok;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_en    <= 1'b0;
      wr_addr  <= BASE;
      wr_data  <= '0;
      wr_count <= '0;
      full     <= 1'b0;
      bad_op   <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      wr_en    <= 1'b0;
      wr_addr  <= BASE;
      wr_count <= '0;
      full     <= 1'b0;
      bad_op   <= 1'b0;
    end else begin
      bad_op <= accept && !fmt_ok;
      if (wr_done) begin
        wr_en    <= 1'b0;
        wr_count <= wr_count + (ADDR_W + 1)'(1);
        if (last_done) begin
          full  <= 1'b1;
          state <= FULL;
        end else begin
          wr_addr <= wr_addr + ADDR_W'(1);
          state   <= IDLE;
        end
      end
      // a bundle accepted alongside the final write has no address left and is discarded
      if (accept && good && !last_done) begin
        wr_en   <= 1'b1;
        wr_data <= word;
        state   <= PEND;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against a transaction-level reference model.
module tb_instr_encoder;

  localparam int unsigned AW = 3;

`ifdef IMM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, in_ready, wr_en, wr_ready, full, bad_op, imm_err;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [31:0]   in_imm, wr_data;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_count;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_count(wr_count), .full(full),
    .bad_op(bad_op), .imm_err(imm_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  bit          m_pend, m_full, m_bad, m_ierr;
  int unsigned m_addr, m_cnt;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int fmt_of(input logic [6:0] op);
    if (op == 7'b0000011 || op == 7'b0010011) return 0;
    if (op == 7'b0100011) return 1;
    if (op == 7'b1100011) return 2;
    return -1;
  endfunction

  function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] u);
    logic [31:0] w;
    w = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (fmt_of(op))
      0: w = w | (32'(rd) << 7) | ((u & 32'hfff) << 20);
      1: w = w | (32'(rs2) << 20) | (((u >> 5) & 32'h7f) << 25) | ((u & 32'h1f) << 7);
      default: w = w | (32'(rs2) << 20) | (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3f) << 25)
                     | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 32'h1) << 7);
    endcase
    return w;
  endfunction

  function automatic bit imm_fits(input logic [6:0] op, input logic [31:0] u);
    int s;
    s = u;
    if (fmt_of(op) == 2) return (u[0] == 1'b0) && s >= -4096 && s <= 4094;
    return s >= -2048 && s <= 2047;
  endfunction

  // core immediate generator for B-type words
  function automatic logic [31:0] immgen_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  task automatic set_in(input logic v, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    in_valid = v; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_imm = imm;
  endtask

  // one clock: check in_ready, advance the model, clock the DUT, check registered outputs
  task automatic tick();
    bit exp_rdy, acc, done, to_full;
    #2;
    exp_rdy = !rst && !clr && !m_full && (!m_pend || wr_ready);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = in_valid && exp_rdy;
    if (rst) begin
      m_pend = 0; m_full = 0; m_bad = 0; m_ierr = 0; m_addr = 0; m_cnt = 0; m_data = '0;
    end else if (clr) begin
      m_pend = 0; m_full = 0; m_bad = 0; m_ierr = 0; m_addr = 0; m_cnt = 0;
    end else begin
      m_bad = 0; m_ierr = 0; to_full = 0;
      done = m_pend && wr_ready;
      if (done) begin
        m_cnt++;
        m_pend = 0;
        if (m_addr == (1 << AW) - 1) begin m_full = 1; to_full = 1; end
        else m_addr++;
      end
      if (acc) begin
        if (fmt_of(in_opcode) < 0) m_bad = 1;
        else if (CHK && !imm_fits(in_opcode, in_imm)) m_ierr = 1;
        else if (!to_full) begin
          m_pend = 1;
          m_data = ref_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
        end
      end
    end
    @(posedge clk);
    #1;
    check("wr_en", 64'(wr_en), 64'(m_pend));
    check("wr_addr", 64'(wr_addr), 64'(m_addr));
    check("wr_data", 64'(wr_data), 64'(m_data));
    check("wr_count", 64'(wr_count), 64'(m_cnt));
    check("full", 64'(full), 64'(m_full));
    check("bad_op", 64'(bad_op), 64'(m_bad));
    check("imm_err", 64'(imm_err), 64'(m_ierr));
  endtask

  initial begin
    int s;
    logic [6:0] ops [5];
    ops[0] = 7'b0000011; ops[1] = 7'b0010011; ops[2] = 7'b0100011;
    ops[3] = 7'b1100011; ops[4] = 7'b0110011;
    m_pend = 0; m_full = 0; m_bad = 0; m_ierr = 0; m_addr = 0; m_cnt = 0; m_data = '0;
    rst = 1; clr = 0; wr_ready = 0;
    set_in(0, '0, '0, '0, '0, '0, '0);
    tick(); tick();
    rst = 0;
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);

    // ADDI x1,x0,5 with memory stalled
    set_in(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    tick();
    check("addi_data", 64'(wr_data), 64'h00500093);
    check("addi_en", 64'(wr_en), 64'd1);
    set_in(0, '0, '0, '0, '0, '0, '0); wr_ready = 1;
    tick();
    clr = 1; tick(); clr = 0;

    // LW then SW back to back
    set_in(1, 7'b0000011, 5'd2, 5'd3, 5'd0, 3'b010, 32'hFFFFFFFC);
    tick();
    check("lw_data", 64'(wr_data), 64'hFFC1A103);
    set_in(1, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 32'd8);
    tick();
    check("sw_data", 64'(wr_data), 64'h00512423);
    check("sw_addr", 64'(wr_addr), 64'd1);
    set_in(0, '0, '0, '0, '0, '0, '0);
    tick();
    check("lwsw_count", 64'(wr_count), 64'd2);

    // BEQ x1,x2,-8 and its round trip through the immediate generator
    set_in(1, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFF8);
    tick();
    check("beq_data", 64'(wr_data), 64'hFE208CE3);
    check("beq_immgen", 64'(immgen_b(wr_data)), 64'hFFFFFFF8);

    // stall: bundle offered but refused for three cycles
    wr_ready = 0;
    set_in(1, 7'b0010011, 5'd4, 5'd4, 5'd0, 3'd0, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    set_in(0, '0, '0, '0, '0, '0, '0); wr_ready = 1;
    tick();
    check("stall_count", 64'(wr_count), 64'd3);
    wr_ready = 0;
    set_in(1, 7'b0010011, 5'd4, 5'd4, 5'd0, 3'd0, 32'd1);
    tick();
    set_in(0, '0, '0, '0, '0, '0, '0);
    tick();
    clr = 1; wr_ready = 1; tick(); clr = 0;
    check("clr_drop_en", 64'(wr_en), 64'd0);
    check("clr_drop_addr", 64'(wr_addr), 64'd0);

    // fill every address
    set_in(1, 7'b0010011, 5'd7, 5'd0, 5'd0, 3'd0, 32'd3);
    for (int i = 0; i < 10; i++) tick();
    check("full_set", 64'(full), 64'd1);
    check("full_count", 64'(wr_count), 64'(1 << AW));
    set_in(0, '0, '0, '0, '0, '0, '0);
    clr = 1; tick(); clr = 0;
    check("full_clr", 64'(full), 64'd0);

    // unsupported opcode, then out-of-range immediate
    set_in(1, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0);
    tick();
    check("badop_pulse", 64'(bad_op), 64'd1);
    set_in(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4096);
    tick();
    check("badop_clear", 64'(bad_op), 64'd0);
    if (CHK) check("imm_err_pulse", 64'(imm_err), 64'd1);
    else     check("imm_trunc", 64'(wr_data), 64'h00000093);
    set_in(0, '0, '0, '0, '0, '0, '0);
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] op;
      op = ops[($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3)];
      if ($urandom_range(0, 4) == 0) s = $urandom();
      else if (op == 7'b1100011) s = (int'($urandom_range(0, 4095)) - 2048) * 2;
      else s = int'($urandom_range(0, 4095)) - 2048;
      set_in($urandom_range(0, 9) < 7, op, 5'($urandom()), 5'($urandom()), 5'($urandom()),
             3'($urandom()), 32'(s));
      wr_ready = $urandom_range(0, 9) < 7;
      clr = $urandom_range(0, 49) == 0;
      rst = $urandom_range(0, 99) == 0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
